// File: rtl/dsm_mod2_mc.sv
// dsm_mod2_mc: time-multiplexed, multi-channel, second-order 1-bit delta-sigma
// modulator. One PCM frame in (CHANNELS signed samples), one 1-bit frame out.
// A single pair of integrator adders walks the channels one per cycle.
//
// Ports:
//   aclk, arst_n          clock, asynchronous active-low reset
//   s_axis_data_*         input frame stream, channel k at [k*WIDTH +: WIDTH]
//   m_axis_data_*         output frame stream, bit k is channel k's DSM bit
//
// Optional feature macro: DSM_SAT_EN (saturating integrators; default wraps).
module dsm_mod2_mc #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned EXT_ACC_1 = 2,
   parameter int unsigned EXT_ACC_2 = 4
) (
   input  logic                      aclk,
   input  logic                      arst_n,
   input  logic [CHANNELS*WIDTH-1:0] s_axis_data_tdata,
   input  logic                      s_axis_data_tvalid,
   output logic                      s_axis_data_tready,
   output logic [CHANNELS-1:0]       m_axis_data_tdata,
   output logic                      m_axis_data_tvalid,
   input  logic                      m_axis_data_tready
);

   localparam int unsigned A1_W = WIDTH + EXT_ACC_1;
   localparam int unsigned A2_W = WIDTH + EXT_ACC_2;
`ifdef DSM_SAT_EN
   // Two guard bits hold the exact three-operand sum before clamping.
   localparam int unsigned S1_W = A1_W + 2;
   localparam int unsigned S2_W = A2_W + 2;
   localparam logic signed [A1_W-1:0] ACC1_MAX = {1'b0, {(A1_W-1){1'b1}}};
   localparam logic signed [A1_W-1:0] ACC1_MIN = {1'b1, {(A1_W-1){1'b0}}};
   localparam logic signed [A2_W-1:0] ACC2_MAX = {1'b0, {(A2_W-1){1'b1}}};
   localparam logic signed [A2_W-1:0] ACC2_MIN = {1'b1, {(A2_W-1){1'b0}}};
`else
   localparam int unsigned S1_W = A1_W;
   localparam int unsigned S2_W = A2_W;
`endif
   localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [1:0]                r_state;
   logic [1:0]                w_state_nxt;
   logic [CH_W-1:0]           r_ch;
   logic [CH_W-1:0]           w_ch_nxt;
   logic                      w_accept;
   logic [CHANNELS*WIDTH-1:0] r_x;
   logic signed [A1_W-1:0]    r_acc1 [CHANNELS];
   logic signed [A2_W-1:0]    r_acc2 [CHANNELS];
   logic [CHANNELS-1:0]       r_prev;
   logic                      r_tready;
   logic                      r_tvalid;
   logic [CHANNELS-1:0]       r_tdata;

   logic signed [WIDTH-1:0]   w_x;
   logic signed [WIDTH-1:0]   w_fb;
   logic signed [S1_W-1:0]    w_sum1;
   logic signed [S2_W-1:0]    w_sum2;
   logic signed [A1_W-1:0]    w_acc1_nxt;
   logic signed [A2_W-1:0]    w_acc2_nxt;
   logic                      w_out;

   assign s_axis_data_tready = r_tready;
   assign m_axis_data_tvalid = r_tvalid;
   assign m_axis_data_tdata  = r_tdata;

   // Next-state logic: IDLE -> CALC (one channel per cycle) -> OUT -> IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (s_axis_data_tvalid && r_tready) begin
               w_accept    = 1'b1;
               w_state_nxt = S_CALC;
               w_ch_nxt    = '0;
            end
         end
         S_CALC: begin
            if (r_ch == CH_LAST) begin
               w_state_nxt = S_OUT;
            end else begin
               w_ch_nxt = r_ch + CH_W'(1);
            end
         end
         S_OUT: begin
            if (m_axis_data_tready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_ch_nxt    = '0;
         end
      endcase
   end

   // Shared integrator datapath for channel r_ch; acc2 consumes the new acc1.
   always_comb begin
      w_x    = r_x[32'(r_ch) * WIDTH +: WIDTH];
      w_fb   = r_prev[r_ch] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      w_sum1 = S1_W'(r_acc1[r_ch]) + S1_W'(w_x) + S1_W'(w_fb);
`ifdef DSM_SAT_EN
      if (w_sum1 > S1_W'(ACC1_MAX)) begin
         w_acc1_nxt = ACC1_MAX;
      end else if (w_sum1 < S1_W'(ACC1_MIN)) begin
         w_acc1_nxt = ACC1_MIN;
      end else begin
         w_acc1_nxt = w_sum1[A1_W-1:0];
      end
`else
      w_acc1_nxt = w_sum1;
`endif
      w_sum2 = S2_W'(r_acc2[r_ch]) + S2_W'(w_acc1_nxt) + S2_W'(w_fb);
`ifdef DSM_SAT_EN
      if (w_sum2 > S2_W'(ACC2_MAX)) begin
         w_acc2_nxt = ACC2_MAX;
      end else if (w_sum2 < S2_W'(ACC2_MIN)) begin
         w_acc2_nxt = ACC2_MIN;
      end else begin
         w_acc2_nxt = w_sum2[A2_W-1:0];
      end
`else
      w_acc2_nxt = w_sum2;
`endif
      w_out = ~w_acc2_nxt[A2_W-1];
   end

   // State, channel state and registered stream outputs.
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         r_state  <= S_IDLE;
         r_ch     <= '0;
         r_x      <= '0;
         r_prev   <= '0;
         r_tready <= 1'b0;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         for (int k = 0; k < int'(CHANNELS); k++) begin
            r_acc1[k] <= '0;
            r_acc2[k] <= '0;
         end
      end else begin
         r_state  <= w_state_nxt;
         r_ch     <= w_ch_nxt;
         r_tready <= (w_state_nxt == S_IDLE);
         r_tvalid <= (w_state_nxt == S_OUT);
         if (w_accept) begin
            r_x <= s_axis_data_tdata;
         end
         if (r_state == S_CALC) begin
            r_acc1[r_ch]  <= w_acc1_nxt;
            r_acc2[r_ch]  <= w_acc2_nxt;
            r_prev[r_ch]  <= w_out;
            r_tdata[r_ch] <= w_out;
         end
      end
   end

endmodule
